// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin sharing of the data-memory port
// between master 0 (core LSU) and master 1 (loader/DMA/debug).
// Ports: clk, reset (async, active-low), m{0,1}_req/we/addr/wdata in,
//   m{0,1}_gnt/rvalid/rdata out, mem_we/re/addr/wdata out, mem_rdata in.
// Optional: `define DMEM_ARB_PERF_EN adds perf_m0_grants,
//   perf_m1_grants and perf_wait_cycles saturating counters.
module dmem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_m0_grants,
  output logic [31:0]       perf_m1_grants,
  output logic [31:0]       perf_wait_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

  state_e            state_q;
  logic              rr_q;
  logic              own_q;
  logic              we_q;
  logic [3:0]        lat_q;
  logic              gnt0_q, gnt1_q;
  logic              rv0_q, rv1_q;
  logic              mem_we_q, mem_re_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              any_req;
  logic              win1_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] cap_d;

  // rr_q=1 favours master 1 when both request.
  assign any_req = m0_req | m1_req;
  assign win1_d  = m1_req & (~m0_req | rr_q);
  assign we_d    = win1_d ? m1_we    : m0_we;
  assign addr_d  = win1_d ? m1_addr  : m0_addr;
  assign wdata_d = win1_d ? m1_wdata : m0_wdata;
  assign cap_d   = we_q ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      own_q    <= 1'b0;
      we_q     <= 1'b0;
      lat_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q  <= ACCESS;
            own_q    <= win1_d;
            rr_q     <= ~win1_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lat_q    <= LAT_INIT;
            gnt0_q   <= ~win1_d;
            gnt1_q   <= win1_d;
            mem_we_q <= we_d;
            mem_re_q <= ~we_d;
          end
        end
        ACCESS: begin
          // single write strobe per transaction
          mem_we_q <= 1'b0;
          if (lat_q == 4'd0) begin
            state_q  <= RESP;
            mem_re_q <= 1'b0;
            if (own_q) begin
              rdata1_q <= cap_d;
              rv1_q    <= 1'b1;
            end else begin
              rdata0_q <= cap_d;
              rv0_q    <= 1'b1;
            end
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m0_gnt    = gnt0_q;
  assign m1_gnt    = gnt1_q;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] pg0_q, pg1_q, pw_q;
  logic        wait_d;

  assign wait_d = (m0_req & ~gnt0_q) | (m1_req & ~gnt1_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pg0_q <= '0;
      pg1_q <= '0;
      pw_q  <= '0;
    end else begin
      if (gnt0_q && !(&pg0_q)) pg0_q <= pg0_q + 32'd1;
      if (gnt1_q && !(&pg1_q)) pg1_q <= pg1_q + 32'd1;
      if (wait_d && !(&pw_q))  pw_q  <= pw_q + 32'd1;
    end
  end

  assign perf_m0_grants   = pg0_q;
  assign perf_m1_grants   = pg1_q;
  assign perf_wait_cycles = pw_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of dmem_port_arbiter
// with MEM_LATENCY=1 (dut a) and MEM_LATENCY=3 (dut b).
module tb_dmem_port_arbiter;

  logic clk;
  logic reset;

  logic        a_m0_req, a_m0_we, a_m0_gnt, a_m0_rvalid;
  logic [31:0] a_m0_addr, a_m0_wdata, a_m0_rdata;
  logic        a_m1_req, a_m1_we, a_m1_gnt, a_m1_rvalid;
  logic [31:0] a_m1_addr, a_m1_wdata, a_m1_rdata;
  logic        a_mem_we, a_mem_re;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_m0_req, b_m0_we, b_m0_gnt, b_m0_rvalid;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata;
  logic        b_m1_req, b_m1_we, b_m1_gnt, b_m1_rvalid;
  logic [31:0] b_m1_addr, b_m1_wdata, b_m1_rdata;
  logic        b_mem_we, b_mem_re;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] a_pg0, a_pg1, a_pw;
  logic [31:0] b_pg0, b_pg1, b_pw;
`endif

  int total;
  int bad;

  dmem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)
  ) u_a (
    .clk(clk), .reset(reset),
    .m0_req(a_m0_req), .m0_we(a_m0_we),
    .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid),
    .m0_rdata(a_m0_rdata),
    .m1_req(a_m1_req), .m1_we(a_m1_we),
    .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid),
    .m1_rdata(a_m1_rdata),
    .mem_we(a_mem_we), .mem_re(a_mem_re),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_m0_grants(a_pg0), .perf_m1_grants(a_pg1),
    .perf_wait_cycles(a_pw)
`endif
  );

  dmem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)
  ) u_b (
    .clk(clk), .reset(reset),
    .m0_req(b_m0_req), .m0_we(b_m0_we),
    .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid),
    .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we),
    .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid),
    .m1_rdata(b_m1_rdata),
    .mem_we(b_mem_we), .mem_re(b_mem_re),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_m0_grants(b_pg0), .perf_m1_grants(b_pg1),
    .perf_wait_cycles(b_pw)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #2;
    total++;
    if ({a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid,
         a_mem_we, a_mem_re} !== 6'b0) begin
      bad++;
      $display("FAIL rst_a_ctl got=%b exp=000000",
        {a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid,
         a_mem_we, a_mem_re});
    end
    total++;
    if ({a_mem_addr, a_mem_wdata, a_m0_rdata, a_m1_rdata} !== 128'd0) begin
      bad++;
      $display("FAIL rst_a_data got=%h %h %h %h exp=0",
        a_mem_addr, a_mem_wdata, a_m0_rdata, a_m1_rdata);
    end
    total++;
    if ({b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid,
         b_mem_we, b_mem_re} !== 6'b0) begin
      bad++;
      $display("FAIL rst_b_ctl got=%b exp=000000",
        {b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid,
         b_mem_we, b_mem_re});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    a_m0_req = 1'b1; a_m0_we = 1'b0;
    a_m0_addr = 32'h10; a_mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if (a_m0_gnt !== 1'b1 || a_m1_gnt !== 1'b0) begin
      bad++;
      $display("FAIL rd_gnt got=%b%b exp=10", a_m0_gnt, a_m1_gnt);
    end
    total++;
    if (a_mem_re !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 32'h10) begin
      bad++;
      $display("FAIL rd_strobe got=re%b we%b addr%h exp=re1 we0 addr10",
        a_mem_re, a_mem_we, a_mem_addr);
    end
    a_m0_req = 1'b0;
    @(negedge clk);
    total++;
    if (a_m0_rvalid !== 1'b1 || a_m0_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL rd_resp got=%b %h exp=1 deadbeef",
        a_m0_rvalid, a_m0_rdata);
    end
    total++;
    if (a_mem_re !== 1'b0 || a_m0_gnt !== 1'b0) begin
      bad++;
      $display("FAIL rd_resp_strobe got=re%b gnt%b exp=0 0",
        a_mem_re, a_m0_gnt);
    end
    @(negedge clk);
    total++;
    if (a_m0_rvalid !== 1'b0 || a_m0_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL rd_hold got=%b %h exp=0 deadbeef",
        a_m0_rvalid, a_m0_rdata);
    end
  endtask

  task automatic test_single_write();
    a_m1_req = 1'b1; a_m1_we = 1'b1;
    a_m1_addr = 32'h20; a_m1_wdata = 32'h12345678;
    @(negedge clk);
    total++;
    if (a_m1_gnt !== 1'b1 || a_m0_gnt !== 1'b0) begin
      bad++;
      $display("FAIL wr_gnt got=%b%b exp=01", a_m0_gnt, a_m1_gnt);
    end
    total++;
    if (a_mem_we !== 1'b1 || a_mem_re !== 1'b0 ||
        a_mem_addr !== 32'h20 || a_mem_wdata !== 32'h12345678) begin
      bad++;
      $display("FAIL wr_strobe got=we%b re%b %h %h exp=1 0 20 12345678",
        a_mem_we, a_mem_re, a_mem_addr, a_mem_wdata);
    end
    a_m1_req = 1'b0;
    @(negedge clk);
    total++;
    if (a_m1_rvalid !== 1'b1 || a_m1_rdata !== 32'h0 || a_mem_we !== 1'b0) begin
      bad++;
      $display("FAIL wr_resp got=rv%b %h we%b exp=1 0 0",
        a_m1_rvalid, a_m1_rdata, a_mem_we);
    end
    total++;
    if (a_m0_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL wr_other_rv got=%b exp=0", a_m0_rvalid);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int   ng;
    logic ord [3];
    ord[0] = 1'bx; ord[1] = 1'bx; ord[2] = 1'bx;
    ng = 0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'h40;
    a_m1_req = 1'b1; a_m1_we = 1'b0; a_m1_addr = 32'h80;
    a_mem_rdata = 32'hC0FFEE00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (a_m0_gnt === 1'b1 && a_m1_gnt === 1'b1) begin
        bad++;
        $display("FAIL cont_dual_gnt cycle=%0d got=11 exp=not both", i);
      end
      total++;
      if (a_m0_rvalid === 1'b1 && a_m1_rvalid === 1'b1) begin
        bad++;
        $display("FAIL cont_dual_rv cycle=%0d got=11 exp=not both", i);
      end
      if (a_m0_gnt === 1'b1 || a_m1_gnt === 1'b1) begin
        if (ng < 3) ord[ng] = a_m1_gnt;
        ng++;
        if (ng == 3) begin
          a_m0_req = 1'b0;
          a_m1_req = 1'b0;
        end
      end
    end
    a_m0_req = 1'b0;
    a_m1_req = 1'b0;
    total++;
    if (ng != 3) begin
      bad++;
      $display("FAIL cont_count got=%0d exp=3", ng);
    end
    total++;
    if (ord[0] !== 1'b0 || ord[1] !== 1'b1 || ord[2] !== 1'b0) begin
      bad++;
      $display("FAIL cont_order got=%b%b%b exp=010", ord[0], ord[1], ord[2]);
    end
    total++;
    if (a_m1_rdata !== 32'hC0FFEE00) begin
      bad++;
      $display("FAIL cont_m1_rdata got=%h exp=c0ffee00", a_m1_rdata);
    end
  endtask

`ifdef DMEM_ARB_PERF_EN
  task automatic test_perf();
    total++;
    if (a_pg0 !== 32'd2 || a_pg1 !== 32'd1) begin
      bad++;
      $display("FAIL perf_grants got=%0d %0d exp=2 1", a_pg0, a_pg1);
    end
    total++;
    if (a_pw !== 32'd7) begin
      bad++;
      $display("FAIL perf_wait got=%0d exp=7", a_pw);
    end
  endtask
`endif

  task automatic test_latency3();
    int re_cnt;
    re_cnt = 0;
    b_m0_req = 1'b1; b_m0_we = 1'b0;
    b_m0_addr = 32'h50; b_mem_rdata = 32'h0;
    @(negedge clk);
    total++;
    if (b_m0_gnt !== 1'b1 || b_mem_addr !== 32'h50) begin
      bad++;
      $display("FAIL l3_gnt got=%b %h exp=1 50", b_m0_gnt, b_mem_addr);
    end
    b_m0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (b_mem_re === 1'b1) re_cnt++;
      total++;
      if (b_m0_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL l3_early_rv cycle=%0d got=1 exp=0", i);
      end
      b_mem_rdata = 32'hA0 + 32'(i + 1);
      @(negedge clk);
    end
    total++;
    if (re_cnt != 3 || b_mem_re !== 1'b0) begin
      bad++;
      $display("FAIL l3_re_len got=%0d re%b exp=3 re0", re_cnt, b_mem_re);
    end
    total++;
    if (b_m0_rvalid !== 1'b1 || b_m0_rdata !== 32'hA3) begin
      bad++;
      $display("FAIL l3_resp got=%b %h exp=1 a3", b_m0_rvalid, b_m0_rdata);
    end
    @(negedge clk);
    b_m1_req = 1'b1; b_m1_we = 1'b1;
    b_m1_addr = 32'h60; b_m1_wdata = 32'h55AA55AA;
    @(negedge clk);
    b_m1_req = 1'b0;
    total++;
    if (b_mem_we !== 1'b1 || b_mem_wdata !== 32'h55AA55AA) begin
      bad++;
      $display("FAIL l3_we_first got=%b %h exp=1 55aa55aa",
        b_mem_we, b_mem_wdata);
    end
    @(negedge clk);
    total++;
    if (b_mem_we !== 1'b0) begin
      bad++;
      $display("FAIL l3_we_second got=%b exp=0", b_mem_we);
    end
    @(negedge clk);
    total++;
    if (b_mem_we !== 1'b0 || b_m1_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL l3_we_third got=we%b rv%b exp=0 0",
        b_mem_we, b_m1_rvalid);
    end
    @(negedge clk);
    total++;
    if (b_m1_rvalid !== 1'b1 || b_m1_rdata !== 32'h0) begin
      bad++;
      $display("FAIL l3_wr_resp got=%b %h exp=1 0", b_m1_rvalid, b_m1_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    a_m1_req = 1'b1; a_m1_we = 1'b0; a_m1_addr = 32'h90;
    a_mem_rdata = 32'h77777777;
    @(negedge clk);
    total++;
    if (a_m1_gnt !== 1'b1 || a_mem_re !== 1'b1) begin
      bad++;
      $display("FAIL rm_access got=gnt%b re%b exp=1 1", a_m1_gnt, a_mem_re);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (a_mem_re !== 1'b0 || a_m1_gnt !== 1'b0) begin
      bad++;
      $display("FAIL rm_drop got=re%b gnt%b exp=0 0", a_mem_re, a_m1_gnt);
    end
    @(negedge clk);
    total++;
    if (a_m1_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rm_no_rv got=%b exp=0", a_m1_rvalid);
    end
    reset = 1'b1;
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'hA0;
    a_m1_req = 1'b1;
    @(negedge clk);
    total++;
    if (a_m0_gnt !== 1'b1 || a_m1_gnt !== 1'b0 || a_m1_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rm_restart got=g0%b g1%b rv1%b exp=1 0 0",
        a_m0_gnt, a_m1_gnt, a_m1_rvalid);
    end
    a_m0_req = 1'b0;
    a_m1_req = 1'b0;
    @(negedge clk);
    total++;
    if (a_m0_rvalid !== 1'b1 || a_m1_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rm_resp got=rv0%b rv1%b exp=1 0",
        a_m0_rvalid, a_m1_rvalid);
    end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    a_m0_req = 0; a_m0_we = 0; a_m0_addr = 0; a_m0_wdata = 0;
    a_m1_req = 0; a_m1_we = 0; a_m1_addr = 0; a_m1_wdata = 0;
    a_mem_rdata = 0;
    b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0;
    b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0;
    b_mem_rdata = 0;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
`ifdef DMEM_ARB_PERF_EN
    test_perf();
`endif
    test_latency3();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: master 0 (core load/store path) and master 1 (loader/DMA/debug).
- Sits between the requesters and Data_Memory, and drives its MemWrite/MemRead/address/write-data inputs.
- Uses round-robin arbitration, a fixed-latency access sequencer, and a one-cycle response pulse back to the winning master.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MEM_LATENCY, 1, cycles from strobe to read data valid at mem_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; all state clears while reset=0.
- m0_req  in  1  master 0 access request; held with m0_we/m0_addr/m0_wdata stable until m0_gnt.
- m0_we  in  1  master 0: 1=write, 0=read.
- m0_addr  in  ADDR_W  master 0 byte address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  one-cycle pulse: master 0 request accepted.
- m0_rvalid  out  1  one-cycle pulse: master 0 access complete; m0_rdata valid.
- m0_rdata  out  DATA_W  master 0 read data (0 for writes).
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- mem_we  out  1  to Data_Memory MemWrite.
- mem_re  out  1  to Data_Memory MemRead.
- mem_addr  out  ADDR_W  to Data_Memory read_address.
- mem_wdata  out  DATA_W  to Data_Memory Write_data.
- mem_rdata  in  DATA_W  from Data_Memory MemData_out.

Behaviour:
- Reset values:
  - State IDLE; rr_ptr=0 (master 0 favoured).
  - All gnt/rvalid/mem_we/mem_re are 0; mem_addr, mem_wdata and rdata registers are 0.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - If any req is high, pick the winner, latch its we/addr/wdata and owner id, load lat_cnt=MEM_LATENCY-1, and go to ACCESS.
  - The winner's gnt is 1 in the first ACCESS cycle only.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: master rr_ptr wins, then rr_ptr := the other master.
  - A single-requester win also sets rr_ptr to the other master.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched values.
  - Read: mem_re=1 for every ACCESS cycle.
  - Write: mem_we=1 in the first ACCESS cycle only (exactly one write strobe per transaction).
  - lat_cnt decrements each cycle. When lat_cnt==0, capture mem_rdata (reads) or 0 (writes) into the owner's rdata register, then go to RESP.
- RESP:
  - Owner's rvalid=1 for one cycle; mem strobes are 0; go to IDLE.
  - rdata holds its value until the next completion for that master.
- Latency: req sampled at edge N → gnt at N+1 → rvalid at N+1+MEM_LATENCY. Throughput is one access per MEM_LATENCY+2 cycles.
- Requests arriving in ACCESS/RESP are not sampled. The requester keeps req high and is serviced from the next IDLE.
- A requester must not drop req before gnt. If it does, the request is simply not seen; no error.
- A master is never granted twice without an intervening rvalid.
- gnt and rvalid are never asserted to both masters in the same cycle.
- Reset asserted mid-transaction:
  - Strobes drop immediately (asynchronous), no rvalid is issued, and the transaction is discarded.
  - After release, the FSM restarts in IDLE with rr_ptr=0.
- Addresses pass through unmodified; no alignment checking.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- When defined, three extra outputs are added:
  - perf_m0_grants [31:0] and perf_m1_grants [31:0]: increment on each gnt pulse.
  - perf_wait_cycles [31:0]: increments every cycle in which any req=1 and that master is not receiving gnt.
  - All three saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single read, MEM_LATENCY=1:
  - Stimulus: m0 reads addr 0x10; memory returns 0xDEADBEEF.
  - Required: m0_gnt at cycle 1; mem_re=1 with mem_addr=0x10 for 1 cycle; m0_rvalid at cycle 2 with m0_rdata=0xDEADBEEF.
- Single write:
  - Stimulus: m1 writes 0x1234_5678 to 0x20.
  - Required: mem_we high for exactly 1 cycle with addr=0x20 and wdata=0x12345678; m1_rvalid one cycle later; m1_rdata=0.
- Contention:
  - Stimulus: m0_req and m1_req both held high for 3 transactions.
  - Required: grant order m0, m1, m0; never two gnt or rvalid pulses in the same cycle.
- MEM_LATENCY=3 read:
  - Stimulus: m0 reads one address.
  - Required: mem_re high 3 cycles; rvalid at cycle 4; captured data equals mem_rdata from the 3rd ACCESS cycle.
- Reset mid-access:
  - Stimulus: reset=0 during ACCESS of an m1 read.
  - Required: mem_re drops within the same cycle; no m1_rvalid; after release, m0 and m1 both requesting gives m0 first.
- DMEM_ARB_PERF_EN:
  - Stimulus: the contention scenario with the macro defined.
  - Required: perf_m0_grants=2, perf_m1_grants=1, perf_wait_cycles equal to the counted cycles in which a pending req had no gnt.
